// File: rtl/my_alu.sv
// rtl/my_alu.sv - 16-bit registered ALU with zero/negative/carry flags
module my_alu (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [15:0] in_A,
    input  logic [15:0] in_B,
    input  logic [4:0]  in_op,
    input  logic        in_cf,
    output logic [15:0] out_C,
    output logic        out_zf,
    output logic        out_nf,
    output logic        out_cf
);

    localparam logic [4:0] OP_PASSA = 5'b00000;
    localparam logic [4:0] OP_PASSB = 5'b00001;
    localparam logic [4:0] OP_NOT   = 5'b00010;
    localparam logic [4:0] OP_NEG   = 5'b00011;
    localparam logic [4:0] OP_AND   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_NOR   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADC   = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SBB   = 5'b01011;
    localparam logic [4:0] OP_INC   = 5'b01100;
    localparam logic [4:0] OP_DEC   = 5'b01101;
    localparam logic [4:0] OP_CMP   = 5'b01110;
    localparam logic [4:0] OP_SLTU  = 5'b01111;
    localparam logic [4:0] OP_SLL   = 5'b10000;
    localparam logic [4:0] OP_SRL   = 5'b10001;
    localparam logic [4:0] OP_SRA   = 5'b10010;
    localparam logic [4:0] OP_ROL   = 5'b10011;
    localparam logic [4:0] OP_ROR   = 5'b10100;
    localparam logic [4:0] OP_RCL   = 5'b10101;
    localparam logic [4:0] OP_RCR   = 5'b10110;
    localparam logic [4:0] OP_SLT   = 5'b10111;
    localparam logic [4:0] OP_SWAP  = 5'b11000;

    logic [3:0]  shamt;
    logic        add_cin;
    logic        sub_bin;
    logic [16:0] sum_ext;
    logic [16:0] diff_ext;
    logic [16:0] inc_ext;
    logic [16:0] dec_ext;
    logic [16:0] neg_ext;
    logic [16:0] sll_ext;
    logic [16:0] srl_ext;
    logic [16:0] sra_ext;
    logic [15:0] rol_val;
    logic [15:0] ror_val;

    logic [15:0] res;
    logic        cf_next;
    logic        load_c;

    assign shamt   = in_B[3:0];
    assign add_cin = (in_op == OP_ADC) & in_cf;
    assign sub_bin = (in_op == OP_SBB) & in_cf;

    // Bit 16 of each extended result is the carry (add) or borrow (subtract).
    assign sum_ext  = {1'b0, in_A} + {1'b0, in_B} + {16'd0, add_cin};
    assign diff_ext = {1'b0, in_A} - {1'b0, in_B} - {16'd0, sub_bin};
    assign inc_ext  = {1'b0, in_A} + 17'd1;
    assign dec_ext  = {1'b0, in_A} - 17'd1;
    assign neg_ext  = 17'd0 - {1'b0, in_A};

    // Shifts carry one extra bit that catches the last bit shifted out; zero when n = 0.
    assign sll_ext = {1'b0, in_A} << shamt;
    assign srl_ext = {in_A, 1'b0} >> shamt;
    assign sra_ext = $signed({in_A, 1'b0}) >>> shamt;

    assign rol_val = (in_A << shamt) | (in_A >> (5'd16 - {1'b0, shamt}));
    assign ror_val = (in_A >> shamt) | (in_A << (5'd16 - {1'b0, shamt}));

    always_comb begin
        res     = 16'd0;
        cf_next = 1'b0;
        load_c  = 1'b1;
        case (in_op)
            OP_PASSA: res = in_A;
            OP_PASSB: res = in_B;
            OP_NOT:   res = ~in_A;
            OP_NEG:   {cf_next, res} = neg_ext;
            OP_AND:   res = in_A & in_B;
            OP_OR:    res = in_A | in_B;
            OP_XOR:   res = in_A ^ in_B;
            OP_NOR:   res = ~(in_A | in_B);
            OP_ADD,
            OP_ADC:   {cf_next, res} = sum_ext;
            OP_SUB,
            OP_SBB:   {cf_next, res} = diff_ext;
            OP_INC:   {cf_next, res} = inc_ext;
            OP_DEC:   {cf_next, res} = dec_ext;
            OP_CMP: begin
                {cf_next, res} = diff_ext;
                load_c = 1'b0;
            end
            OP_SLTU:  res = {15'd0, in_A < in_B};
            OP_SLL:   {cf_next, res} = sll_ext;
            OP_SRL:   {res, cf_next} = srl_ext;
            OP_SRA:   {res, cf_next} = sra_ext;
            OP_ROL: begin
                res     = rol_val;
                cf_next = (shamt != 4'd0) & rol_val[0];
            end
            OP_ROR: begin
                res     = ror_val;
                cf_next = (shamt != 4'd0) & ror_val[15];
            end
            OP_RCL: begin
                res     = {in_A[14:0], in_cf};
                cf_next = in_A[15];
            end
            OP_RCR: begin
                res     = {in_cf, in_A[15:1]};
                cf_next = in_A[0];
            end
            OP_SLT:   res = {15'd0, $signed(in_A) < $signed(in_B)};
            OP_SWAP:  res = {in_A[7:0], in_A[15:8]};
            default: begin
                res     = 16'd0;
                cf_next = 1'b0;
            end
        endcase
    end

    // CMP updates flags from the difference but leaves out_C untouched.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_C  <= 16'd0;
            out_zf <= 1'b0;
            out_nf <= 1'b0;
            out_cf <= 1'b0;
        end else begin
            if (load_c) begin
                out_C <= res;
            end
            out_zf <= (res == 16'd0);
            out_nf <= res[15];
            out_cf <= cf_next;
        end
    end

endmodule

// File: tb/tb_my_alu.sv
// tb/tb_my_alu.sv - directed and random scoreboard bench for my_alu
module tb_my_alu;

    logic        in_clk;
    logic        in_rst_n;
    logic [15:0] in_A;
    logic [15:0] in_B;
    logic [4:0]  in_op;
    logic        in_cf;
    logic [15:0] out_C;
    logic        out_zf;
    logic        out_nf;
    logic        out_cf;

    typedef struct {
        logic [15:0] c;
        logic        zf;
        logic        nf;
        logic        cf;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    my_alu dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .in_A     (in_A),
        .in_B     (in_B),
        .in_op    (in_op),
        .in_cf    (in_cf),
        .out_C    (out_C),
        .out_zf   (out_zf),
        .out_nf   (out_nf),
        .out_cf   (out_cf)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic pop_check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            assert ({out_C, out_zf, out_nf, out_cf} === {e.c, e.zf, e.nf, e.cf})
            else begin
                errors++;
                $error("FAIL %s: got C=%h zf=%b nf=%b cf=%b expected C=%h zf=%b nf=%b cf=%b",
                       e.tag, out_C, out_zf, out_nf, out_cf, e.c, e.zf, e.nf, e.cf);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({out_C, out_zf, out_nf, out_cf} === 19'd0)
        else begin
            errors++;
            $error("FAIL %s: got C=%h zf=%b nf=%b cf=%b expected all zero",
                   tag, out_C, out_zf, out_nf, out_cf);
        end
    endtask

    task automatic step(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] c, input logic zf,
                        input logic nf, input logic cf, input string tag);
        exp_t e;
        @(negedge in_clk);
        in_op = op;
        in_A  = a;
        in_B  = b;
        in_cf = cin;
        e.c = c; e.zf = zf; e.nf = nf; e.cf = cf; e.tag = tag;
        sb.push_back(e);
        @(posedge in_clk);
        #1;
        pop_check();
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [16:0] wide;
        logic [15:0] rc;
        logic        rcf;
        int          sel;

        in_rst_n = 1'b1;
        in_A  = 16'h0;
        in_B  = 16'h0;
        in_op = 5'b0;
        in_cf = 1'b0;

        #1;
        in_rst_n = 1'b0;
        in_A  = 16'($urandom);
        in_B  = 16'($urandom);
        in_op = 5'($urandom);
        in_cf = 1'($urandom);
        #1;
        check_zero("reset_async");
        @(posedge in_clk);
        #1;
        check_zero("reset_held");
        @(negedge in_clk);
        in_rst_n = 1'b1;

        step(5'b01000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 0, 0, "add_zero");
        step(5'b01000, 16'h0003, 16'h0004, 1'b0, 16'h0007, 0, 0, 0, "add_3_4");
        step(5'b01000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, "add_wrap");
        step(5'b01001, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 1, "adc_wrap");
        step(5'b01010, 16'h0003, 16'h0004, 1'b0, 16'hFFFF, 0, 1, 1, "sub_borrow");
        step(5'b01011, 16'h0005, 16'h0002, 1'b1, 16'h0002, 0, 0, 0, "sbb");
        step(5'b01110, 16'h0005, 16'h0005, 1'b0, 16'h0002, 1, 0, 0, "cmp_hold");
        step(5'b01110, 16'h0003, 16'h0004, 1'b0, 16'h0002, 0, 1, 1, "cmp_borrow");
        step(5'b10010, 16'h8001, 16'h0001, 1'b0, 16'hC000, 0, 1, 1, "sra_1");
        step(5'b10000, 16'h8001, 16'h0001, 1'b0, 16'h0002, 0, 0, 1, "sll_1");
        step(5'b10001, 16'h8001, 16'h0001, 1'b0, 16'h4000, 0, 0, 1, "srl_1");
        step(5'b10000, 16'h8001, 16'h0000, 1'b0, 16'h8001, 0, 1, 0, "sll_0");
        step(5'b10001, 16'h8000, 16'h000F, 1'b0, 16'h0001, 0, 0, 0, "srl_15");
        step(5'b10101, 16'h8000, 16'h0001, 1'b1, 16'h0001, 0, 0, 1, "rcl");
        step(5'b10110, 16'h0001, 16'h0000, 1'b1, 16'h8000, 0, 1, 1, "rcr");
        step(5'b10011, 16'h1234, 16'h0004, 1'b0, 16'h2341, 0, 0, 1, "rol_4");
        step(5'b10100, 16'h1234, 16'h0004, 1'b0, 16'h4123, 0, 0, 0, "ror_4");
        step(5'b10011, 16'h8234, 16'h0000, 1'b0, 16'h8234, 0, 1, 0, "rol_0");
        step(5'b10111, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 0, 0, 0, "slt");
        step(5'b01111, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 0, "sltu");
        step(5'b00111, 16'h00FF, 16'h0F00, 1'b0, 16'hF000, 0, 1, 0, "nor");
        step(5'b11010, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1, 0, 0, "reserved");
        step(5'b01101, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 0, 1, 1, "dec_zero");
        step(5'b01100, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1, 0, 1, "inc_wrap");
        step(5'b00011, 16'h8000, 16'h0000, 1'b0, 16'h8000, 0, 1, 1, "neg_8000");
        step(5'b00011, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 0, 0, "neg_zero");
        step(5'b11000, 16'h1234, 16'h0000, 1'b0, 16'h3412, 0, 0, 0, "swap");
        step(5'b00010, 16'h00F0, 16'h0000, 1'b0, 16'hFF0F, 0, 1, 0, "not");
        step(5'b00001, 16'h1111, 16'hABCD, 1'b0, 16'hABCD, 0, 1, 0, "passb");

        for (int i = 0; i < 40; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            sel = $urandom_range(0, 4);
            rcf = 1'b0;
            case (sel)
                0: begin wide = 17'(ra) + 17'(rb); rc = wide[15:0]; rcf = wide[16]; end
                1: begin rc = 16'(ra - rb); rcf = (ra < rb); end
                2: rc = ra & rb;
                3: rc = ra | rb;
                default: rc = ra ^ rb;
            endcase
            case (sel)
                0: step(5'b01000, ra, rb, 1'b0, rc, rc == 0, rc[15], rcf, "rand_add");
                1: step(5'b01010, ra, rb, 1'b0, rc, rc == 0, rc[15], rcf, "rand_sub");
                2: step(5'b00100, ra, rb, 1'b0, rc, rc == 0, rc[15], rcf, "rand_and");
                3: step(5'b00101, ra, rb, 1'b0, rc, rc == 0, rc[15], rcf, "rand_or");
                default: step(5'b00110, ra, rb, 1'b0, rc, rc == 0, rc[15], rcf, "rand_xor");
            endcase
        end

        // Reset pulse mid-stream between clock edges while ADD is running.
        step(5'b01000, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1, 0, 1, "add_before_rst");
        step(5'b01000, 16'h0100, 16'h8001, 1'b0, 16'h8101, 0, 1, 0, "add_running");
        #2;
        in_rst_n = 1'b0;
        #1;
        check_zero("reset_midstream");
        @(negedge in_clk);
        in_rst_n = 1'b1;
        in_op = 5'b01000;
        in_A  = 16'h1234;
        in_B  = 16'h1111;
        #1;
        check_zero("reset_released_no_edge");
        step(5'b01000, 16'h1234, 16'h1111, 1'b0, 16'h2345, 0, 0, 0, "add_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/my_alu.md
Name: my_alu

Overview:
- 16-bit registered ALU for the processor datapath.
- Computes one of 25 operations on two 16-bit operands, selected by a 5-bit opcode, with carry-in.
- Produces the result plus zero, negative and carry flags, all registered on the clock.
- Fed by the register file / decode stage; flags go to the status register and branch logic.

Parameters:
- None. Width fixed at 16; opcode fixed at 5 bits.

Ports:
- in_clk  input  1  system clock; all outputs update on the rising edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_A  input  16  operand A.
- in_B  input  16  operand B; low 4 bits are the shift/rotate amount.
- in_op  input  5  opcode.
- in_cf  input  1  carry/borrow in, from the status register.
- out_C  output  16  registered result.
- out_zf  output  1  registered zero flag.
- out_nf  output  1  registered negative flag.
- out_cf  output  1  registered carry/borrow flag.

Behaviour:
- Reset: in_rst_n low clears out_C, out_zf, out_nf and out_cf to 0 immediately, regardless of the clock. They are held at 0 while reset is low.
- After reset release: a combinational result and flags are computed from the current inputs and captured on every rising edge. There is no enable.
- Latency: exactly 1 cycle; inputs present before edge N appear after edge N.
- Flags, default rule: zf = (result == 0); nf = result[15]; cf as listed per op.
- Opcodes (cf in brackets; "cf=0" unless stated):
  - 00000 PASSA: A.
  - 00001 PASSB: B.
  - 00010 NOT: ~A.
  - 00011 NEG: 0-A [cf = (A != 0)].
  - 00100 AND, 00101 OR, 00110 XOR, 00111 NOR.
  - 01000 ADD: A+B [cf = bit 16 of the 17-bit sum].
  - 01001 ADC: A+B+in_cf [carry out].
  - 01010 SUB: A-B [cf = borrow, i.e. A < B unsigned].
  - 01011 SBB: A-B-in_cf [cf = borrow, i.e. A < B+in_cf unsigned].
  - 01100 INC: A+1 [carry out].
  - 01101 DEC: A-1 [cf = (A == 0)].
  - 01110 CMP: flags computed exactly as SUB; out_C holds its previous value. zf/nf here come from the A-B difference, not from out_C.
  - 01111 SLTU: C = 1 if A < B unsigned, else 0.
  - 10000 SLL: A << n, n = B[3:0] [cf = last bit shifted out].
  - 10001 SRL: logical A >> n [cf = last bit shifted out].
  - 10010 SRA: arithmetic A >> n, sign-filled [cf = last bit shifted out].
  - For SLL/SRL/SRA with n = 0: result = A and cf = 0.
  - 10011 ROL: rotate left by n [cf = result[0] if n != 0, else 0].
  - 10100 ROR: rotate right by n [cf = result[15] if n != 0, else 0].
  - 10101 RCL: 1-bit rotate left through carry: result = {A[14:0], in_cf}, cf = A[15].
  - 10110 RCR: 1-bit rotate right through carry: result = {in_cf, A[15:1]}, cf = A[0].
  - 10111 SLT: C = 1 if A < B signed, else 0.
  - 11000 SWAP: {A[7:0], A[15:8]}.
  - 11001..11111 reserved: C = 0, zf = 1, nf = 0, cf = 0.
- Width rules:
  - All arithmetic is modulo 2^16.
  - Overflow is not flagged.
  - Signed compare uses two's complement.
- Boundaries:
  - FFFF+1 gives 0, zf=1, cf=1.
  - 0-1 gives FFFF, nf=1, cf=1.
  - NEG 8000 gives 8000, nf=1, cf=1.
- Reset asserted mid-stream: outputs go to 0 at once. The first valid result appears at the first rising edge after release.

Test Plan:
- Reset low with random inputs -> all outputs 0 asynchronously, with no clock edge. Release, apply op=01000, A=0, B=0 -> after 1 edge: C=0000, zf=1, nf=0, cf=0.
- op=01000, A=3, B=4 -> next edge: C=0007, zf=0, nf=0, cf=0. Then A=FFFF, B=0001 -> C=0000, zf=1, cf=1.
- op=01010, A=3, B=4 -> C=FFFF, nf=1, cf=1. Then op=01011, A=5, B=2, in_cf=1 -> C=0002, cf=0. Then op=01110, A=5, B=5 -> C stays 0002, zf=1, cf=0.
- Shift/rotate, B=1:
  - op=10010, A=8001 -> C=C000, nf=1, cf=1.
  - op=10000, A=8001 -> C=0002, cf=1.
  - op=10101, A=8000, in_cf=1 -> C=0001, cf=1.
  - op=10011, A=1234, B=4 -> C=2341.
- Compare/logic:
  - op=10111, A=FFFF, B=0001 -> C=0001.
  - op=01111 with the same operands -> C=0000, zf=1.
  - op=00111, A=00FF, B=0F00 -> C=F000, nf=1.
  - op=11010 (reserved) -> C=0000, zf=1.
- Assert reset between edges while the ALU is running ADD -> outputs drop to 0 immediately. Release -> the correct sum appears one edge later.
